// File: rtl/cmult_pkg.sv
// Shared types and saturating arithmetic helpers for the complex
// integrate-and-dump datapath.
package cmult_pkg;

  localparam int WIDEW = 64;

  typedef logic signed [WIDEW-1:0] wide_t;

  typedef struct packed {
    wide_t re;
    wide_t im;
  } cplx_t;

  function automatic wide_t lim_hi(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t lim_lo(input int w);
    return -lim_hi(w) - wide_t'(1);
  endfunction

  function automatic logic out_of_range(input wide_t x, input int w);
    return (x > lim_hi(w)) || (x < lim_lo(w));
  endfunction

  function automatic wide_t clip(input wide_t x, input int w);
    if (x > lim_hi(w)) return lim_hi(w);
    if (x < lim_lo(w)) return lim_lo(w);
    return x;
  endfunction

  function automatic wide_t sat_add(
    input wide_t a,
    input wide_t b,
    input int    w
  );
    return clip(a + b, w);
  endfunction

  function automatic logic sat_add_ovf(
    input wide_t a,
    input wide_t b,
    input int    w
  );
    return out_of_range(a + b, w);
  endfunction

  // Round half up, then arithmetic shift.
  function automatic wide_t round_shift(input wide_t x, input int sh);
    wide_t h;
    h = (sh > 0) ? (wide_t'(1) <<< (sh - 1)) : '0;
    return (x + h) >>> sh;
  endfunction

  function automatic wide_t round_shift_sat(
    input wide_t x,
    input int    sh,
    input int    w
  );
    return clip(round_shift(x, sh), w);
  endfunction

  function automatic logic round_shift_ovf(
    input wide_t x,
    input int    sh,
    input int    w
  );
    return out_of_range(round_shift(x, sh), w);
  endfunction

  function automatic cplx_t cplx_sat_add(
    input cplx_t a,
    input cplx_t b,
    input int    w
  );
    cplx_t r;
    r.re = sat_add(a.re, b.re, w);
    r.im = sat_add(a.im, b.im, w);
    return r;
  endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// Round, shift and saturate one component into a load-enabled
// output register.
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int IW    = 40,
  parameter int OW    = 32,
  parameter int SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [IW-1:0] i_x,
  output logic [OW-1:0] o_y,
  output logic          o_sat
);

  logic [OW-1:0] r_y;
  logic          r_sat;
  wide_t         w_x;

  assign w_x = wide_t'($signed(i_x));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y   <= '0;
      r_sat <= 1'b0;
    end else if (i_en) begin
      r_y   <= OW'(round_shift_sat(w_x, SHIFT, OW));
      r_sat <= round_shift_ovf(w_x, SHIFT, OW);
    end
  end

  assign o_y   = r_y;
  assign o_sat = r_sat;

endmodule

// File: rtl/cmult_integrate_dump.sv
// Complex integrate-and-dump: saturating window accumulation, a
// capture stage, then a rounded/saturated valid/ready output.
module cmult_integrate_dump
  import cmult_pkg::*;
#(
  parameter int DWIDTH   = 16,
  parameter int ACCWIDTH = 40,
  parameter int NWIDTH   = 16,
  parameter int OWIDTH   = 32,
  parameter int OSHIFT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic [NWIDTH-1:0] i_cfg_len,
  input  logic              i_s_valid,
  input  logic [DWIDTH-1:0] i_s_re,
  input  logic [DWIDTH-1:0] i_s_im,
  input  logic              i_s_ovf,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [OWIDTH-1:0] o_m_re,
  output logic [OWIDTH-1:0] o_m_im,
  output logic              o_m_ovf,
  output logic              o_err_drop
);

  logic signed [ACCWIDTH-1:0] r_acc_re;
  logic signed [ACCWIDTH-1:0] r_acc_im;
  logic [NWIDTH-1:0]          r_cnt;
  logic [NWIDTH-1:0]          r_len;
  logic                       r_wovf;

  logic                r_s1_valid;
  logic                r_s1_ovf;
  logic [ACCWIDTH-1:0] r_s1_re;
  logic [ACCWIDTH-1:0] r_s1_im;

  logic r_m_valid;
  logic r_m_ovf;
  logic r_err_drop;

  logic [NWIDTH-1:0]   w_len_cfg;
  logic [ACCWIDTH-1:0] w_sum_re;
  logic [ACCWIDTH-1:0] w_sum_im;
  logic                w_sat;
  logic                w_take;
  logic                w_dump;
  logic                w_restart;
  logic                w_load;
  logic                w_drop;
  logic [OWIDTH-1:0]   w_y_re;
  logic [OWIDTH-1:0]   w_y_im;
  logic                w_ysat_re;
  logic                w_ysat_im;

  assign w_len_cfg = (i_cfg_len == '0) ? NWIDTH'(1) : i_cfg_len;

  assign w_sum_re = ACCWIDTH'(sat_add(wide_t'(r_acc_re),
                    wide_t'($signed(i_s_re)), ACCWIDTH));
  assign w_sum_im = ACCWIDTH'(sat_add(wide_t'(r_acc_im),
                    wide_t'($signed(i_s_im)), ACCWIDTH));
  assign w_sat = sat_add_ovf(wide_t'(r_acc_re),
                 wide_t'($signed(i_s_re)), ACCWIDTH)
               | sat_add_ovf(wide_t'(r_acc_im),
                 wide_t'($signed(i_s_im)), ACCWIDTH);

  // clr wins over a same-cycle sample.
  assign w_take    = i_s_valid && !i_clr;
  assign w_dump    = w_take && (r_cnt == r_len - NWIDTH'(1));
  assign w_restart = i_clr || w_dump;

  assign w_load = r_s1_valid && (!r_m_valid || i_m_ready);
  assign w_drop = r_s1_valid && r_m_valid && !i_m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || w_restart) begin
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_cnt    <= '0;
      r_wovf   <= 1'b0;
      r_len    <= w_len_cfg;
    end else if (w_take) begin
      r_acc_re <= w_sum_re;
      r_acc_im <= w_sum_im;
      r_cnt    <= r_cnt + NWIDTH'(1);
      r_wovf   <= r_wovf | i_s_ovf | w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_re    <= '0;
      r_s1_im    <= '0;
    end else begin
      r_s1_valid <= w_dump;
      if (w_dump) begin
        r_s1_re  <= w_sum_re;
        r_s1_im  <= w_sum_im;
        r_s1_ovf <= r_wovf | i_s_ovf | w_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_valid  <= 1'b0;
      r_m_ovf    <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_ovf   <= r_s1_ovf;
      end else if (i_m_ready) begin
        r_m_valid <= 1'b0;
      end
      if (i_clr) begin
        r_err_drop <= 1'b0;
      end else if (w_drop) begin
        r_err_drop <= 1'b1;
      end
    end
  end

  cmult_round_sat #(
    .IW    (ACCWIDTH),
    .OW    (OWIDTH),
    .SHIFT (OSHIFT)
  ) u_re (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_load),
    .i_x   (r_s1_re),
    .o_y   (w_y_re),
    .o_sat (w_ysat_re)
  );

  cmult_round_sat #(
    .IW    (ACCWIDTH),
    .OW    (OWIDTH),
    .SHIFT (OSHIFT)
  ) u_im (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_load),
    .i_x   (r_s1_im),
    .o_y   (w_y_im),
    .o_sat (w_ysat_im)
  );

  assign o_m_valid  = r_m_valid;
  assign o_m_re     = w_y_re;
  assign o_m_im     = w_y_im;
  assign o_m_ovf    = r_m_ovf | w_ysat_re | w_ysat_im;
  assign o_err_drop = r_err_drop;

endmodule

// File: tb/tb_cmult_integrate_dump.sv
// Randomised bench for cmult_integrate_dump: three parameterisations
// share one stimulus stream and are checked against a window model.
module tb_cmult_integrate_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] cfg_len = 16'd4;
  logic        s_valid = 1'b0;
  logic [15:0] s_re = '0;
  logic [15:0] s_im = '0;
  logic        s_ovf = 1'b0;
  logic        m_ready = 1'b1;

  logic        v0, v1, v2, o0, o1, o2, e0, e1, e2;
  logic [31:0] re0, im0, re1, im1;
  logic [15:0] re2, im2;

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  cmult_integrate_dump #(
    .DWIDTH(16), .ACCWIDTH(40), .NWIDTH(16), .OWIDTH(32), .OSHIFT(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_cfg_len(cfg_len),
    .i_s_valid(s_valid), .i_s_re(s_re), .i_s_im(s_im), .i_s_ovf(s_ovf),
    .o_m_valid(v0), .i_m_ready(m_ready), .o_m_re(re0), .o_m_im(im0),
    .o_m_ovf(o0), .o_err_drop(e0)
  );

  cmult_integrate_dump #(
    .DWIDTH(16), .ACCWIDTH(20), .NWIDTH(16), .OWIDTH(32), .OSHIFT(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_cfg_len(cfg_len),
    .i_s_valid(s_valid), .i_s_re(s_re), .i_s_im(s_im), .i_s_ovf(s_ovf),
    .o_m_valid(v1), .i_m_ready(m_ready), .o_m_re(re1), .o_m_im(im1),
    .o_m_ovf(o1), .o_err_drop(e1)
  );

  cmult_integrate_dump #(
    .DWIDTH(16), .ACCWIDTH(40), .NWIDTH(16), .OWIDTH(16), .OSHIFT(2)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_cfg_len(cfg_len),
    .i_s_valid(s_valid), .i_s_re(s_re), .i_s_im(s_im), .i_s_ovf(s_ovf),
    .o_m_valid(v2), .i_m_ready(m_ready), .o_m_re(re2), .o_m_im(im2),
    .o_m_ovf(o2), .o_err_drop(e2)
  );

  logic              av[3];
  logic              ao[3];
  logic              ae[3];
  logic signed [63:0] ar[3];
  logic signed [63:0] ai[3];

  always_comb begin
    av[0] = v0; av[1] = v1; av[2] = v2;
    ao[0] = o0; ao[1] = o1; ao[2] = o2;
    ae[0] = e0; ae[1] = e1; ae[2] = e2;
    ar[0] = 64'($signed(re0));
    ar[1] = 64'($signed(re1));
    ar[2] = 64'($signed(re2));
    ai[0] = 64'($signed(im0));
    ai[1] = 64'($signed(im1));
    ai[2] = 64'($signed(im2));
  end

  localparam int AW [3] = '{40, 20, 40};
  localparam int OW [3] = '{32, 32, 16};
  localparam int SH [3] = '{0, 0, 2};

  typedef struct packed {
    logic [2:0][63:0] re;
    logic [2:0][63:0] im;
    logic [2:0]       ovf;
    int               due;
  } exp_t;

  exp_t   q[$];
  exp_t   e;
  bit     ev;
  longint m_re[3];
  longint m_im[3];
  bit     m_ovf[3];
  int     m_cnt;
  int     m_len;

  function automatic longint clampw(longint x, int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic bit outw(longint x, int w);
    return clampw(x, w) != x;
  endfunction

  function automatic longint rnd(int span);
    return longint'($urandom_range(2 * span)) - longint'(span);
  endfunction

  function automatic longint scale(longint x, int sh);
    longint h;
    h = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
    return (x + h) >>> sh;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_re[d] = 0;
      m_im[d] = 0;
      m_ovf[d] = 1'b0;
    end
    m_cnt = 0;
    m_len = (cfg_len == 16'd0) ? 1 : int'(cfg_len);
  endtask

  // Drive one cycle and advance the window model on the same edge.
  task automatic tick(bit v, longint re, longint im, bit ov);
    exp_t   ne;
    longint nr, ni, yr, yi;
    s_valid = v;
    s_re = re[15:0];
    s_im = im[15:0];
    s_ovf = ov;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      q.delete();
    end else if (clr) begin
      model_reset();
    end else if (v) begin
      for (int d = 0; d < 3; d++) begin
        nr = m_re[d] + re;
        ni = m_im[d] + im;
        m_ovf[d] = m_ovf[d] | ov | outw(nr, AW[d]) | outw(ni, AW[d]);
        m_re[d] = clampw(nr, AW[d]);
        m_im[d] = clampw(ni, AW[d]);
      end
      m_cnt++;
      if (m_cnt == m_len) begin
        for (int d = 0; d < 3; d++) begin
          yr = scale(m_re[d], SH[d]);
          yi = scale(m_im[d], SH[d]);
          ne.re[d] = clampw(yr, OW[d]);
          ne.im[d] = clampw(yi, OW[d]);
          ne.ovf[d] = m_ovf[d] | outw(yr, OW[d]) | outw(yi, OW[d]);
        end
        ne.due = cyc + 2;
        q.push_back(ne);
        model_reset();
      end
    end
    #1;
    cyc++;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick(0, 0, 0, 0);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_len = 16'd4;
    tick(0, 0, 0, 0);
    tick(1, 123, 456, 1);
    for (int d = 0; d < 3; d++) begin
      n_tot++;
      if ({av[d], ao[d], ae[d], ar[d], ai[d]} !== '0) begin
        n_bad++;
        $display("FAIL reset dut%0d got v=%b ovf=%b err=%b re=%0d im=%0d want all 0",
                 d, av[d], ao[d], ae[d], ar[d], ai[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_window();
    for (int i = 0; i < 15; i++) begin
      if (i < 12) tick(1, 1000, -1000, 0);
      else tick(0, 0, 0, 0);
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) e = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        n_tot++;
        if (av[d] !== ev || (ev && (ar[d] !== e.re[d] || ai[d] !== e.im[d]
            || ao[d] !== e.ovf[d]) ) || (ev && d < 2 && ar[d] !== 4000)) begin
          n_bad++;
          $display("FAIL window dut%0d cyc=%0d got v=%b re=%0d im=%0d ovf=%b want v=%b re=%0d im=%0d ovf=%b",
                   d, cyc, av[d], ar[d], ai[d], ao[d], ev,
                   $signed(e.re[d]), $signed(e.im[d]), e.ovf[d]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    longint vals [3] = '{1, 2, 3};
    cfg_len = 16'd3;
    clr_pulse();
    for (int i = 0; i < 27; i++) begin
      if (i < 24 && i % 2 == 0) tick(1, vals[(i / 2) % 3], rnd(50), 0);
      else tick(0, 0, 0, 0);
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) e = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        n_tot++;
        if (av[d] !== ev || (ev && (ar[d] !== e.re[d] || ai[d] !== e.im[d]
            || ao[d] !== e.ovf[d])) || (ev && d == 0 && ar[0] !== 6)) begin
          n_bad++;
          $display("FAIL gaps dut%0d cyc=%0d got v=%b re=%0d im=%0d ovf=%b want v=%b re=%0d im=%0d ovf=%b",
                   d, cyc, av[d], ar[d], ai[d], ao[d], ev,
                   $signed(e.re[d]), $signed(e.im[d]), e.ovf[d]);
        end
      end
    end
  endtask

  task automatic test_len_zero();
    cfg_len = 16'd0;
    clr_pulse();
    for (int i = 0; i < 33; i++) begin
      if (i < 30) tick(1'($urandom_range(1)), rnd(32767), rnd(32767), 0);
      else tick(0, 0, 0, 0);
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) e = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        n_tot++;
        if (av[d] !== ev || (ev && (ar[d] !== e.re[d] || ai[d] !== e.im[d]
            || ao[d] !== e.ovf[d]))) begin
          n_bad++;
          $display("FAIL len0 dut%0d cyc=%0d got v=%b re=%0d im=%0d ovf=%b want v=%b re=%0d im=%0d ovf=%b",
                   d, cyc, av[d], ar[d], ai[d], ao[d], ev,
                   $signed(e.re[d]), $signed(e.im[d]), e.ovf[d]);
        end
      end
    end
  endtask

  task automatic test_acc_sat();
    int k = 0;
    cfg_len = 16'd64;
    clr_pulse();
    for (int i = 0; i < 71; i++) begin
      if (i == 10) cfg_len = 16'd4;
      if (i < 64) tick(1, 32767, -32768, 0);
      else if (i < 68) tick(1, rnd(100), rnd(100), 0);
      else tick(0, 0, 0, 0);
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) e = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        n_tot++;
        if (av[d] !== ev || (ev && (ar[d] !== e.re[d] || ai[d] !== e.im[d]
            || ao[d] !== e.ovf[d]))) begin
          n_bad++;
          $display("FAIL accsat dut%0d cyc=%0d got v=%b re=%0d im=%0d ovf=%b want v=%b re=%0d im=%0d ovf=%b",
                   d, cyc, av[d], ar[d], ai[d], ao[d], ev,
                   $signed(e.re[d]), $signed(e.im[d]), e.ovf[d]);
        end
      end
      if (ev) begin
        n_tot++;
        if (k == 0 && (ar[1] !== 524287 || ai[1] !== -524288 || ao[1] !== 1'b1)) begin
          n_bad++;
          $display("FAIL accclamp got re=%0d im=%0d ovf=%b want re=524287 im=-524288 ovf=1",
                   ar[1], ai[1], ao[1]);
        end
        if (k == 1 && ao[1] !== 1'b0) begin
          n_bad++;
          $display("FAIL ovfclear got ovf=%b want 0", ao[1]);
        end
        k++;
      end
    end
  endtask

  task automatic test_round();
    longint tin [6] = '{6, -6, 5, -5, 2, -2};
    longint tout [6] = '{2, -1, 1, -1, 1, 0};
    int k = 0;
    cfg_len = 16'd1;
    clr_pulse();
    for (int i = 0; i < 9; i++) begin
      if (i < 6) tick(1, tin[i], -tin[i], 0);
      else tick(0, 0, 0, 0);
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) e = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        n_tot++;
        if (av[d] !== ev || (ev && (ar[d] !== e.re[d] || ai[d] !== e.im[d]
            || ao[d] !== e.ovf[d]))) begin
          n_bad++;
          $display("FAIL round dut%0d cyc=%0d got v=%b re=%0d im=%0d ovf=%b want v=%b re=%0d im=%0d ovf=%b",
                   d, cyc, av[d], ar[d], ai[d], ao[d], ev,
                   $signed(e.re[d]), $signed(e.im[d]), e.ovf[d]);
        end
      end
      if (ev && k < 6) begin
        n_tot++;
        if (ar[2] !== tout[k]) begin
          n_bad++;
          $display("FAIL roundtab in=%0d got %0d want %0d", tin[k], ar[2], tout[k]);
        end
        k++;
      end
    end
  endtask

  task automatic test_out_sat();
    int k = 0;
    cfg_len = 16'd8;
    clr_pulse();
    for (int i = 0; i < 19; i++) begin
      if (i < 8) tick(1, 30000, -30000, 0);
      else if (i < 16) tick(1, -30000, 30000, 0);
      else tick(0, 0, 0, 0);
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) e = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        n_tot++;
        if (av[d] !== ev || (ev && (ar[d] !== e.re[d] || ai[d] !== e.im[d]
            || ao[d] !== e.ovf[d]))) begin
          n_bad++;
          $display("FAIL outsat dut%0d cyc=%0d got v=%b re=%0d im=%0d ovf=%b want v=%b re=%0d im=%0d ovf=%b",
                   d, cyc, av[d], ar[d], ai[d], ao[d], ev,
                   $signed(e.re[d]), $signed(e.im[d]), e.ovf[d]);
        end
      end
      if (ev) begin
        n_tot++;
        if (ar[2] !== ((k == 0) ? 32767 : -32768) || ao[2] !== 1'b1
            || ao[0] !== 1'b0 || ar[0] !== ((k == 0) ? 240000 : -240000)) begin
          n_bad++;
          $display("FAIL outclamp k=%0d got re2=%0d ovf2=%b re0=%0d ovf0=%b",
                   k, ar[2], ao[2], ar[0], ao[0]);
        end
        k++;
      end
    end
  endtask

  task automatic test_back_to_back();
    cfg_len = 16'd1;
    clr_pulse();
    for (int i = 0; i < 43; i++) begin
      if (i < 40) tick(1, rnd(32767), rnd(32767), 1'($urandom_range(7) == 0));
      else tick(0, 0, 0, 0);
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) e = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        n_tot++;
        if (av[d] !== ev || (ev && (ar[d] !== e.re[d] || ai[d] !== e.im[d]
            || ao[d] !== e.ovf[d]))) begin
          n_bad++;
          $display("FAIL b2b dut%0d cyc=%0d got v=%b re=%0d im=%0d ovf=%b want v=%b re=%0d im=%0d ovf=%b",
                   d, cyc, av[d], ar[d], ai[d], ao[d], ev,
                   $signed(e.re[d]), $signed(e.im[d]), e.ovf[d]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t ea;
    m_ready = 1'b0;
    tick(1, rnd(32767), rnd(32767), 0);
    ea = q[0];
    tick(1, rnd(32767), rnd(32767), 0);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick(0, 0, 0, 0);
      for (int d = 0; d < 3; d++) begin
        n_tot++;
        if (av[d] !== 1'b1 || ar[d] !== ea.re[d] || ai[d] !== ea.im[d]
            || ao[d] !== ea.ovf[d] || ae[d] !== (j > 0)) begin
          n_bad++;
          $display("FAIL hold dut%0d j=%0d got v=%b re=%0d im=%0d err=%b want v=1 re=%0d im=%0d err=%b",
                   d, j, av[d], ar[d], ai[d], ae[d],
                   $signed(ea.re[d]), $signed(ea.im[d]), j > 0);
        end
      end
    end
    m_ready = 1'b1;
    tick(0, 0, 0, 0);
    for (int d = 0; d < 3; d++) begin
      n_tot++;
      if (av[d] !== 1'b0 || ae[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL drain dut%0d got v=%b err=%b want v=0 err=1", d, av[d], ae[d]);
      end
    end
    clr_pulse();
    for (int d = 0; d < 3; d++) begin
      n_tot++;
      if (ae[d] !== 1'b0 || av[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL errclr dut%0d got err=%b v=%b want 0 0", d, ae[d], av[d]);
      end
    end
    q.delete();
  endtask

  task automatic test_reset_midwindow();
    longint fsum = 0;
    longint x;
    int k = 0;
    cfg_len = 16'd4;
    clr_pulse();
    tick(1, rnd(1000), rnd(1000), 1);
    tick(1, rnd(1000), rnd(1000), 0);
    rst_n = 1'b0;
    tick(1, rnd(1000), rnd(1000), 0);
    for (int d = 0; d < 3; d++) begin
      n_tot++;
      if ({av[d], ao[d], ae[d], ar[d], ai[d]} !== '0) begin
        n_bad++;
        $display("FAIL midrst dut%0d got v=%b ovf=%b err=%b re=%0d im=%0d want all 0",
                 d, av[d], ao[d], ae[d], ar[d], ai[d]);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 2) cfg_len = 16'd2;
      if (i < 12) begin
        x = rnd(20000);
        if (i < 4) fsum += x;
        tick(1, x, rnd(20000), 0);
      end else begin
        tick(0, 0, 0, 0);
      end
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) e = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        n_tot++;
        if (av[d] !== ev || (ev && (ar[d] !== e.re[d] || ai[d] !== e.im[d]
            || ao[d] !== e.ovf[d]))) begin
          n_bad++;
          $display("FAIL postrst dut%0d cyc=%0d got v=%b re=%0d im=%0d ovf=%b want v=%b re=%0d im=%0d ovf=%b",
                   d, cyc, av[d], ar[d], ai[d], ao[d], ev,
                   $signed(e.re[d]), $signed(e.im[d]), e.ovf[d]);
        end
      end
      if (ev) begin
        if (k == 0) begin
          n_tot++;
          if (ar[0] !== fsum || ao[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL freshsum got re=%0d ovf=%b want re=%0d ovf=0", ar[0], ao[0], fsum);
          end
        end
        k++;
      end
    end
    n_tot++;
    if (k != 5) begin
      n_bad++;
      $display("FAIL wincount got %0d results want 5", k);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_window();
    test_gaps();
    test_len_zero();
    test_acc_sat();
    test_round();
    test_out_sat();
    test_back_to_back();
    test_backpressure();
    test_reset_midwindow();
    n_tot++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover got %0d pending results want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
